// File: rtl/latency_scoreboard_mc.sv
// Multi-channel latency-emulation buffer. Requests are held for a fixed or
// LFSR-derived number of cycles, then presented show-ahead through a round-robin arbiter.
module latency_scoreboard_mc #(
  parameter int          NUM_TRANSACTIONS = 16,
  parameter int          HDR_WIDTH        = 72,
  parameter int          DATA_WIDTH       = 512,
  parameter int          NUM_CHANNELS     = 2,
  parameter int          MIN_LATENCY      = 4,
  parameter int          LAT_RANGE_LOG2   = 3,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  localparam int         CH_W             = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int         CNT_W            = $clog2(NUM_TRANSACTIONS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HDR_WIDTH-1:0]  meta_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CH_W-1:0]       chan_in,
  input  logic                  valid_in,
  input  logic                  ooo_mode,
  input  logic                  fixed_lat,
  output logic [HDR_WIDTH-1:0]  meta_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CH_W-1:0]       chan_out,
  output logic                  valid_out,
  input  logic                  read_en,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int          NT       = NUM_TRANSACTIONS;
  localparam int          IDX_W    = $clog2(NUM_TRANSACTIONS);
  localparam int          LAT_W    = $clog2(MIN_LATENCY + (1 << LAT_RANGE_LOG2)) + 1;
  localparam logic [15:0] LAT_MASK = 16'((32'd1 << LAT_RANGE_LOG2) - 32'd1);

  logic [NT-1:0]           slot_valid_r;
  logic [HDR_WIDTH-1:0]    slot_meta_r [NT];
  logic [DATA_WIDTH-1:0]   slot_data_r [NT];
  logic [CH_W-1:0]         slot_chan_r [NT];
  logic [LAT_W-1:0]        slot_cd_r   [NT];
  // older_r[i][j] is set when slot i was written before slot j
  logic [NT-1:0]           older_r     [NT];
  logic [IDX_W-1:0]        lock_idx_r;
  logic [CH_W-1:0]         rr_r;
  logic [15:0]             lfsr_r;

  logic                    wr_s;
  logic                    pop_s;
  logic [IDX_W-1:0]        free_idx_s;
  logic [LAT_W-1:0]        lat_s;
  logic [15:0]             lfsr_next_s;
  logic [CNT_W-1:0]        count_next_s;
  logic [CH_W-1:0]         rr_next_s;
  logic [NT-1:0]           elig_s;
  logic [NUM_CHANNELS-1:0] ch_has_s;
  logic                    sel_found_s;
  logic [CH_W-1:0]         sel_ch_s;
  logic [IDX_W-1:0]        sel_idx_s;

  // Write/pop qualification, lowest free slot, latency and next-state helpers
  always_comb begin
    wr_s       = valid_in & ~full;
    pop_s      = read_en & valid_out;
    free_idx_s = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      free_idx_s = slot_valid_r[i] ? free_idx_s : IDX_W'(i);
    end
    lat_s        = fixed_lat ? LAT_W'(MIN_LATENCY)
                             : LAT_W'(MIN_LATENCY) + LAT_W'(lfsr_r & LAT_MASK);
    lfsr_next_s  = lfsr_r[0] ? ({1'b0, lfsr_r[15:1]} ^ 16'hB400) : {1'b0, lfsr_r[15:1]};
    count_next_s = count + CNT_W'(wr_s) - CNT_W'(pop_s);
    rr_next_s    = (chan_out == CH_W'(NUM_CHANNELS - 1)) ? CH_W'(0) : chan_out + CH_W'(1);
  end

  // A slot may be locked on the edge its countdown reaches zero, so its output
  // is visible right after that edge; in-order mode also requires it to be the oldest of its channel
  always_comb begin
    logic blocked;
    elig_s = '0;
    for (int i = 0; i < NT; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < NT; j++) begin
        blocked = blocked | (slot_valid_r[j] & older_r[j][i] & (slot_chan_r[j] == slot_chan_r[i]));
      end
      elig_s[i] = slot_valid_r[i] & (slot_cd_r[i] <= LAT_W'(1)) & (ooo_mode | ~blocked);
    end
  end

  // Round-robin channel pick from rr_r upward, then lowest eligible slot in that channel
  always_comb begin
    logic [CH_W-1:0] cidx;
    cidx     = '0;
    ch_has_s = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int i = 0; i < NT; i++) begin
        ch_has_s[c] = ch_has_s[c] | (elig_s[i] & (slot_chan_r[i] == CH_W'(c)));
      end
    end
    sel_found_s = |ch_has_s;
    sel_ch_s    = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      cidx     = CH_W'((int'(rr_r) + k) % NUM_CHANNELS);
      sel_ch_s = ch_has_s[cidx] ? cidx : sel_ch_s;
    end
    sel_idx_s = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      sel_idx_s = (elig_s[i] & (slot_chan_r[i] == sel_ch_s)) ? IDX_W'(i) : sel_idx_s;
    end
  end

  // Request payload storage; contents are only meaningful while the slot is valid
  always_ff @(posedge clk) begin
    if (wr_s) begin
      slot_meta_r[free_idx_s] <= meta_in;
      slot_data_r[free_idx_s] <= data_in;
      slot_chan_r[free_idx_s] <= chan_in;
    end
  end

  // Slot occupancy, countdowns, age order, lock, arbiter pointer and status
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= '0;
      for (int i = 0; i < NT; i++) begin
        slot_cd_r[i] <= '0;
        older_r[i]   <= '0;
      end
      lock_idx_r <= '0;
      rr_r       <= '0;
      lfsr_r     <= LFSR_SEED;
      valid_out  <= 1'b0;
      meta_out   <= '0;
      data_out   <= '0;
      chan_out   <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      lfsr_r    <= lfsr_next_s;
      count     <= count_next_s;
      empty     <= (count_next_s == CNT_W'(0));
      full      <= (count_next_s == CNT_W'(NT));
      overflow  <= overflow | (valid_in & full);
      underflow <= underflow | (read_en & ~valid_out);
      for (int i = 0; i < NT; i++) begin
        slot_cd_r[i] <= (slot_cd_r[i] != LAT_W'(0)) ? slot_cd_r[i] - LAT_W'(1) : slot_cd_r[i];
      end
      if (pop_s) begin
        slot_valid_r[lock_idx_r] <= 1'b0;
        valid_out                <= 1'b0;
        rr_r                     <= rr_next_s;
      end else if (!valid_out && sel_found_s) begin
        valid_out  <= 1'b1;
        lock_idx_r <= sel_idx_s;
        meta_out   <= slot_meta_r[sel_idx_s];
        data_out   <= slot_data_r[sel_idx_s];
        chan_out   <= slot_chan_r[sel_idx_s];
      end
      if (wr_s) begin
        slot_valid_r[free_idx_s] <= 1'b1;
        slot_cd_r[free_idx_s]    <= lat_s - LAT_W'(1);
        for (int j = 0; j < NT; j++) begin
          older_r[free_idx_s][j] <= 1'b0;
          older_r[j][free_idx_s] <= slot_valid_r[j];
        end
      end
    end
  end
endmodule

// File: tb/tb_latency_scoreboard_mc.sv
// Self-checking bench for latency_scoreboard_mc: directed test-plan steps plus a
// randomized phase, all compared cycle by cycle against a slot-level behavioural model.
module tb_latency_scoreboard_mc;
  localparam int          NT   = 16;
  localparam int          HW   = 72;
  localparam int          DW   = 512;
  localparam int          NCH  = 2;
  localparam int          MINL = 4;
  localparam int          LR   = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          CW   = 1;
  localparam int          CNTW = 5;
  localparam logic [HW-1:0] T1_META = 72'h01_0000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [HW-1:0]   meta_in;
  logic [DW-1:0]   data_in;
  logic [CW-1:0]   chan_in;
  logic            valid_in;
  logic            ooo_mode;
  logic            fixed_lat;
  logic [HW-1:0]   meta_out;
  logic [DW-1:0]   data_out;
  logic [CW-1:0]   chan_out;
  logic            valid_out;
  logic            read_en;
  logic            empty;
  logic            full;
  logic [CNTW-1:0] count;
  logic            overflow;
  logic            underflow;

  always #5 clk = ~clk;

  latency_scoreboard_mc #(
    .NUM_TRANSACTIONS(NT), .HDR_WIDTH(HW), .DATA_WIDTH(DW), .NUM_CHANNELS(NCH),
    .MIN_LATENCY(MINL), .LAT_RANGE_LOG2(LR), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .meta_in(meta_in), .data_in(data_in), .chan_in(chan_in),
    .valid_in(valid_in), .ooo_mode(ooo_mode), .fixed_lat(fixed_lat),
    .meta_out(meta_out), .data_out(data_out), .chan_out(chan_out), .valid_out(valid_out),
    .read_en(read_en), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Behavioural model: a table of occupied slots with absolute ready edges and write order
  bit            m_valid [NT];
  logic [HW-1:0] m_meta  [NT];
  logic [DW-1:0] m_data  [NT];
  int            m_chan  [NT];
  int            m_ready [NT];
  int            m_seq   [NT];
  bit            m_lock;
  int            m_lock_slot;
  int            m_rr;
  int            m_count;
  bit            m_ovf;
  bit            m_unf;
  logic [15:0]   m_lfsr;
  int            m_edge = 0;
  int            m_seqctr = 0;
  logic [HW-1:0] m_meta_out;
  logic [DW-1:0] m_data_out;
  logic [CW-1:0] m_chan_out;
  logic [HW-1:0] popped_meta [$];
  int            popped_chan [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic bit has_older(input int i);
    for (int j = 0; j < NT; j++)
      if (m_valid[j] && m_chan[j] == m_chan[i] && m_seq[j] < m_seq[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit eligible(input int i);
    return m_valid[i] && (m_edge >= m_ready[i]) && (ooo_mode || !has_older(i));
  endfunction

  function automatic void model_edge();
    int fs, pick, lat, c;
    bit lock_pre, full_pre;
    if (rst) begin
      for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
      m_lock = 0; m_lock_slot = 0; m_rr = 0; m_count = 0; m_ovf = 0; m_unf = 0;
      m_lfsr = SEED; m_meta_out = '0; m_data_out = '0; m_chan_out = '0;
      return;
    end
    m_edge++;
    lock_pre = m_lock;
    full_pre = (m_count == NT);
    fs = -1;
    for (int i = NT - 1; i >= 0; i--) if (!m_valid[i]) fs = i;
    if (!lock_pre) begin
      pick = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (pick < 0) begin
          for (int i = 0; i < NT; i++) begin
            if (eligible(i) && m_chan[i] == c) begin
              if (pick < 0) pick = i;
              else if (!ooo_mode && m_seq[i] < m_seq[pick]) pick = i;
            end
          end
        end
      end
      if (pick >= 0) begin
        m_lock = 1; m_lock_slot = pick;
        m_meta_out = m_meta[pick]; m_data_out = m_data[pick]; m_chan_out = CW'(m_chan[pick]);
      end
    end
    if (read_en && lock_pre) begin
      m_valid[m_lock_slot] = 1'b0;
      m_lock = 0;
      m_rr = (m_chan[m_lock_slot] + 1) % NCH;
      m_count--;
    end
    if (read_en && !lock_pre) m_unf = 1;
    if (valid_in && full_pre) m_ovf = 1;
    if (valid_in && !full_pre) begin
      lat = MINL + (fixed_lat ? 0 : int'(m_lfsr) % (1 << LR));
      m_valid[fs] = 1'b1; m_meta[fs] = meta_in; m_data[fs] = data_in;
      m_chan[fs] = int'(chan_in); m_ready[fs] = m_edge + lat - 1;
      m_seq[fs] = m_seqctr; m_seqctr++;
      m_count++;
    end
    m_lfsr = lfsr_step(m_lfsr);
  endfunction

  task automatic check_all();
    chk({phase, ".valid_out"}, DW'(valid_out), DW'(m_lock));
    chk({phase, ".count"},     DW'(count),     DW'(m_count));
    chk({phase, ".empty"},     DW'(empty),     DW'(m_count == 0));
    chk({phase, ".full"},      DW'(full),      DW'(m_count == NT));
    chk({phase, ".overflow"},  DW'(overflow),  DW'(m_ovf));
    chk({phase, ".underflow"}, DW'(underflow), DW'(m_unf));
    chk({phase, ".chan_out"},  DW'(chan_out),  DW'(m_chan_out));
    chk({phase, ".meta_out"},  DW'(meta_out),  DW'(m_meta_out));
    chk({phase, ".data_out"},  data_out,       m_data_out);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [HW-1:0] rand_meta();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[HW-1:0];
  endfunction

  task automatic step(input bit vin, input int ch, input logic [HW-1:0] mt, input bit ren);
    valid_in = vin; chan_in = CW'(ch); meta_in = mt; data_in = rand_data(); read_en = ren;
    if (ren && m_lock) begin
      popped_meta.push_back(meta_out);
      popped_chan.push_back(int'(chan_out));
    end
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int seen [11];
    bit vin, ren;
    rst = 1'b1; valid_in = 1'b0; read_en = 1'b0; ooo_mode = 1'b0; fixed_lat = 1'b0;
    meta_in = '0; data_in = '0; chan_in = '0;

    // Fixed latency: visible three edges after the write edge, popped on the fourth
    phase = "t1"; do_reset(); fixed_lat = 1'b1;
    step(1'b1, 0, T1_META, 1'b0);
    step(1'b0, 0, '0, 1'b0); chk("t1_wait1", DW'(valid_out), DW'(1'b0));
    step(1'b0, 0, '0, 1'b0); chk("t1_wait2", DW'(valid_out), DW'(1'b0));
    step(1'b0, 0, '0, 1'b0); chk("t1_valid", DW'(valid_out), DW'(1'b1));
    chk("t1_meta", DW'(meta_out), DW'(T1_META));
    step(1'b0, 0, '0, 1'b1); chk("t1_empty", DW'(empty), DW'(1'b1));
    chk("t1_drop", DW'(valid_out), DW'(1'b0));

    // Fill, overflow and its clearing by reset
    phase = "t2"; do_reset(); fixed_lat = 1'b1;
    for (int i = 0; i < NT; i++) step(1'b1, i % 2, rand_meta(), 1'b0);
    chk("t2_full", DW'(full), DW'(1'b1)); chk("t2_count16", DW'(count), DW'(16));
    chk("t2_no_ovf", DW'(overflow), DW'(1'b0));
    step(1'b1, 0, rand_meta(), 1'b0);
    chk("t2_ovf", DW'(overflow), DW'(1'b1)); chk("t2_count_hold", DW'(count), DW'(16));
    do_reset(); chk("t2_ovf_clr", DW'(overflow), DW'(1'b0));

    // Underflow on an empty buffer
    phase = "t3";
    step(1'b0, 0, '0, 1'b1);
    chk("t3_unf", DW'(underflow), DW'(1'b1)); chk("t3_count", DW'(count), DW'(0));
    chk("t3_valid", DW'(valid_out), DW'(1'b0));

    // In-order release within one channel, then out-of-order release of the same traffic
    phase = "t4_io"; do_reset(); ooo_mode = 1'b0; fixed_lat = 1'b0; popped_meta.delete();
    for (int i = 1; i <= 10; i++) step(1'b1, 1, HW'(i), 1'b0);
    for (int n = 0; n < 60; n++) step(1'b0, 0, '0, m_lock);
    chk("t4_io_pops", DW'(popped_meta.size()), DW'(10));
    foreach (popped_meta[i]) chk("t4_io_order", DW'(popped_meta[i]), DW'(i + 1));
    phase = "t4_ooo"; do_reset(); ooo_mode = 1'b1; popped_meta.delete();
    for (int i = 1; i <= 10; i++) step(1'b1, 1, HW'(i), 1'b0);
    for (int n = 0; n < 60; n++) step(1'b0, 0, '0, m_lock);
    chk("t4_ooo_pops", DW'(popped_meta.size()), DW'(10));
    for (int v = 0; v < 11; v++) seen[v] = 0;
    foreach (popped_meta[i]) if (popped_meta[i] <= 10) seen[int'(popped_meta[i])]++;
    for (int v = 1; v <= 10; v++) chk("t4_ooo_once", DW'(seen[v]), DW'(1));

    // Channel fairness with read_en held high
    phase = "t5"; do_reset(); ooo_mode = 1'b0; fixed_lat = 1'b1; popped_chan.delete();
    for (int i = 0; i < 8; i++) step(1'b1, i % 2, HW'(i + 1), 1'b0);
    for (int n = 0; n < 8; n++) step(1'b0, 0, '0, 1'b0);
    for (int n = 0; n < 24; n++) step(1'b0, 0, '0, 1'b1);
    chk("t5_pops", DW'(popped_chan.size()), DW'(8));
    foreach (popped_chan[i]) chk("t5_rr", DW'(popped_chan[i]), DW'(i % 2));

    // Reset mid-operation; LFSR restarts from the seed, so the first random latency is 4 + 1
    phase = "t6"; do_reset(); fixed_lat = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, i % 2, rand_meta(), 1'b0);
    step(1'b0, 0, '0, 1'b0); step(1'b0, 0, '0, 1'b0);
    do_reset();
    chk("t6_valid", DW'(valid_out), DW'(1'b0)); chk("t6_count", DW'(count), DW'(0));
    step(1'b1, 0, T1_META, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b0, 0, '0, 1'b0);
    chk("t6_lfsr_wait", DW'(valid_out), DW'(1'b0));
    step(1'b0, 0, '0, 1'b0); chk("t6_lfsr_valid", DW'(valid_out), DW'(1'b1));
    step(1'b0, 0, '0, 1'b1);
    fixed_lat = 1'b1;
    step(1'b1, 1, T1_META, 1'b0);
    step(1'b0, 0, '0, 1'b0); step(1'b0, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b0); chk("t6_fixed_valid", DW'(valid_out), DW'(1'b1));
    chk("t6_fixed_chan", DW'(chan_out), DW'(1'b1));

    // Randomized traffic in both modes, with full, overflow and underflow occurring
    phase = "rand"; do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      ooo_mode = seg[0];
      for (int n = 0; n < 150; n++) begin
        fixed_lat = ($urandom % 4 == 0);
        vin = ($urandom % 3 != 0);
        ren = m_lock ? bit'($urandom % 2) : ($urandom % 16 == 0);
        step(vin, int'($urandom % 2), rand_meta(), ren);
      end
    end
    for (int n = 0; n < 60; n++) step(1'b0, 0, '0, m_lock);
    chk("rand_drained", DW'(empty), DW'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
